// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input conditioner: default parameter values,
// the repeat-timer phase type and the width helpers used by every file.
package input_conditioner_pkg;

  localparam int DEF_N_CH            = 4;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_REPEAT_DELAY    = 500;
  localparam int DEF_REPEAT_PERIOD   = 100;

  // Auto-repeat timer phase: waiting for the first repeat, then periodic.
  typedef enum logic {
    RPT_DELAY  = 1'b0,
    RPT_PERIOD = 1'b1
  } rpt_phase_e;

  // $clog2 clamped to at least one bit so a counter never collapses to zero width.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/input_cond_channel.sv
// One conditioned input channel: synchroniser chain, debounce counter,
// registered level with one-cycle rise/fall pulses, and (when the macro
// INPUT_COND_REPEAT_EN is defined) an auto-repeat timer for held inputs.
// With the macro undefined rpt_o is tied low and no timer exists.
module input_cond_channel
  import input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic rpt_o
);

  // Reject configurations the counters cannot represent.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("input_cond_channel: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("input_cond_channel: DEBOUNCE_CYCLES must be >= 1");
  end
  if ((REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_bad_repeat
    $error("input_cond_channel: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  localparam int                CNT_W    = clog2_min1(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Shift the raw input through the synchroniser chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Debounce decision: count consecutive disagreeing samples, commit on the last one.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (synced != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = synced;
        rise_d  = synced;
        fall_d  = ~synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state and pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

`ifdef INPUT_COND_REPEAT_EN
  localparam int               RPT_W    = clog2_min1(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] tmr_q, tmr_d;
  rpt_phase_e       phase_q, phase_d;
  logic             rpt_q, rpt_d;

  // Repeat timer: restart on rise, fire after the delay and then every period,
  // and stop as soon as the level drops (the falling commit included).
  always_comb begin
    tmr_d   = '0;
    phase_d = RPT_DELAY;
    rpt_d   = 1'b0;
    if (rise_d) begin
      tmr_d   = '0;
      phase_d = RPT_DELAY;
    end else if (level_q && !fall_d) begin
      phase_d = phase_q;
      if ((phase_q == RPT_DELAY) && (tmr_q == DLY_LAST)) begin
        phase_d = RPT_PERIOD;
        rpt_d   = 1'b1;
      end else if ((phase_q == RPT_PERIOD) && (tmr_q == PER_LAST)) begin
        rpt_d   = 1'b1;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end
  end

  // Repeat timer state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr_q   <= '0;
      phase_q <= RPT_DELAY;
      rpt_q   <= 1'b0;
    end else begin
      tmr_q   <= tmr_d;
      phase_q <= phase_d;
      rpt_q   <= rpt_d;
    end
  end

  assign rpt_o = rpt_q;
`else
  assign rpt_o = 1'b0;
`endif

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: N_CH independent synchronise/debounce
// channels producing clean levels, rise/fall pulses and an any_rise summary.
// Auto-repeat pulses on rpt exist only when INPUT_COND_REPEAT_EN is defined;
// otherwise rpt is constant zero.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int N_CH            = DEF_N_CH,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] rpt,
  output logic            any_rise
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    input_cond_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .in_i   (in[i]),
      .level_o(level[i]),
      .rise_o (rise[i]),
      .fall_o (fall[i]),
      .rpt_o  (rpt[i])
    );
  end

  // Registered rise bits reduced combinationally, so any_rise is aligned with rise.
  assign any_rise = |rise;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner (default parameters; REPEAT_DELAY=10 and
// REPEAT_PERIOD=4 when INPUT_COND_REPEAT_EN is defined).
module tb_input_conditioner;

`ifdef INPUT_COND_REPEAT_EN
  localparam int RD = 10;
  localparam int RP = 4;
`else
  localparam int RD = 500;
  localparam int RP = 100;
`endif

  typedef logic [16:0] vec_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] in    = 4'h0;
  logic [3:0] level, rise, fall, rpt;
  logic       any_rise;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t exp_q[$];

  input_conditioner #(
    .N_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset), .in(in), .level(level), .rise(rise),
    .fall(fall), .rpt(rpt), .any_rise(any_rise)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] l, input logic [3:0] r,
                              input logic [3:0] f, input logic [3:0] p);
    return {l, r, f, p, |r};
  endfunction

  // Hold reset for three edges with the given input, release #1 after an edge.
  task automatic apply_reset(input logic [3:0] init);
    reset = 1'b0;
    in    = init;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    vec_t got, want;
    reset = 1'b0;
    in    = 4'hF;
    for (int c = 1; c <= 3; c++) begin
      exp_q.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0));
      @(posedge clk); #1;
      got = {level, rise, fall, rpt, any_rise};
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset_hold c=%0d got=%h want=%h", c, got, want);
      end
    end
    reset = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      exp_q.push_back(mk((c >= 6) ? 4'hF : 4'h0, (c == 6) ? 4'hF : 4'h0, 4'h0, 4'h0));
      @(posedge clk); #1;
      got = {level, rise, fall, rpt, any_rise};
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset_release c=%0d got=%h want=%h", c, got, want);
      end
    end
  endtask

  // Two 3-sample glitches (neither commits, and the second would if the count
  // had not cleared), then a 4-cycle pulse that does commit.
  task automatic test_glitch();
    vec_t got, want;
    logic [3:0] l, r, f;
    apply_reset(4'h0);
    for (int c = 1; c <= 34; c++) begin
      in[0] = ((c >= 1) && (c <= 3)) || ((c >= 11) && (c <= 13)) || ((c >= 21) && (c <= 24));
      l = {3'b0, (c >= 26) && (c < 30)};
      r = {3'b0, c == 26};
      f = {3'b0, c == 30};
      exp_q.push_back(mk(l, r, f, 4'h0));
      @(posedge clk); #1;
      got = {level, rise, fall, rpt, any_rise};
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL glitch c=%0d got=%h want=%h", c, got, want);
      end
    end
    in = 4'h0;
  endtask

  task automatic test_press_release();
    vec_t got, want;
    logic [3:0] l, r, f;
    apply_reset(4'h0);
    for (int c = 1; c <= 30; c++) begin
      in[1] = (c <= 20);
      l = {2'b0, (c >= 6) && (c < 26), 1'b0};
      r = {2'b0, c == 6, 1'b0};
      f = {2'b0, c == 26, 1'b0};
      exp_q.push_back(mk(l, r, f, 4'h0));
      @(posedge clk); #1;
      got = {level, rise, fall, rpt, any_rise};
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL press_release c=%0d got=%h want=%h", c, got, want);
      end
    end
    in = 4'h0;
  endtask

  // in[0] and in[3] start together with different bounce; commits land on
  // the edge five after each input's last change.
  task automatic test_independent();
    vec_t got, want;
    logic [3:0] l, r, f;
    logic [7:0] bounce3;
    bounce3 = 8'b1101_0011; // bit k-1 is in[3] at edge k for k=1..8
    apply_reset(4'h0);
    for (int c = 1; c <= 32; c++) begin
      in[0] = (c == 1) || ((c >= 3) && (c <= 19));
      if (c <= 8) in[3] = bounce3[c-1];
      else        in[3] = (c <= 19) || (c == 21);
      l = {(c >= 12) && (c < 27), 2'b0, (c >= 8) && (c < 25)};
      r = {c == 12, 2'b0, c == 8};
      f = {c == 27, 2'b0, c == 25};
      exp_q.push_back(mk(l, r, f, 4'h0));
      @(posedge clk); #1;
      got = {level, rise, fall, rpt, any_rise};
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL independent c=%0d got=%h want=%h", c, got, want);
      end
    end
    in = 4'h0;
  endtask

  task automatic test_reset_mid();
    vec_t got, want;
    apply_reset(4'h0);
    in[2] = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      exp_q.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0));
      @(posedge clk); #1;
      got = {level, rise, fall, rpt, any_rise};
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL pend_pre c=%0d got=%h want=%h", c, got, want);
      end
    end
    reset = 1'b0;
    for (int c = 4; c <= 6; c++) begin
      exp_q.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0));
      @(posedge clk); #1;
      got = {level, rise, fall, rpt, any_rise};
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL pend_in_reset c=%0d got=%h want=%h", c, got, want);
      end
    end
    reset = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      exp_q.push_back(mk((c >= 6) ? 4'h4 : 4'h0, (c == 6) ? 4'h4 : 4'h0, 4'h0, 4'h0));
      @(posedge clk); #1;
      got = {level, rise, fall, rpt, any_rise};
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL pend_post c=%0d got=%h want=%h", c, got, want);
      end
    end
    // Assert reset while the rise pulse is showing: it must clear without a clock edge.
    reset = 1'b0;
    #1;
    exp_q.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0));
    got = {level, rise, fall, rpt, any_rise};
    want = exp_q.pop_front();
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL pulse_async_clear got=%h want=%h", got, want);
    end
    in = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      exp_q.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0));
      @(posedge clk); #1;
      got = {level, rise, fall, rpt, any_rise};
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL pulse_after_release c=%0d got=%h want=%h", c, got, want);
      end
    end
  endtask

  task automatic test_repeat();
    vec_t got, want;
    logic [3:0] l, r, f, p;
    apply_reset(4'h0);
    for (int c = 1; c <= 40; c++) begin
      in[0] = (c <= 30);
      l = {3'b0, (c >= 6) && (c < 36)};
      r = {3'b0, c == 6};
      f = {3'b0, c == 36};
`ifdef INPUT_COND_REPEAT_EN
      p = {3'b0, (c >= 6 + RD) && (c < 36) && (((c - 6 - RD) % RP) == 0)};
`else
      p = 4'h0;
`endif
      exp_q.push_back(mk(l, r, f, p));
      @(posedge clk); #1;
      got = {level, rise, fall, rpt, any_rise};
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL repeat c=%0d got=%h want=%h", c, got, want);
      end
    end
    in = 4'h0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_press_release();
    test_independent();
    test_reset_mid();
    test_repeat();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
